// File: rtl/nibble_serial_adder.sv
// Serial adder: one 4-bit carry-lookahead slice per edge; result valid NIBBLES edges after accept.
// in_ready only in IDLE; result held in DONE until out_ready, in_valid ignored while busy.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  input  logic                 cin,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [4*NIBBLES-1:0] out,
  output logic                 cout,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;

  logic [3:0]    a_nib;
  logic [3:0]    b_nib;
  logic [4:0]    slice;

  // Returns {carry_out, sum[3:0]}; every carry is a flat generate/propagate term.
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic c0);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c[4], p ^ c[3:0]};
  endfunction

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (cnt_q == CW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
    slice = cla4(a_nib, b_nib, carry_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        // Only the nibble selected by the counter is rewritten this edge.
        for (int i = 0; i < NIBBLES; i++) begin
          if (cnt_q == CW'(i)) out_d[4*i +: 4] = slice[3:0];
        end
        carry_d = slice[4];
        if (cnt_q == CW'(NIBBLES - 1)) begin
          cout_d  = slice[4];
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  assign out  = out_q;
  assign cout = cout_q;

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter NIBBLES, default 4: number of 4-bit nibbles per operand; operand width W = 4*NIBBLES.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port A, input, W: operand A, sampled on accept.
REQ-005 SHALL have port B, input, W: operand B, sampled on accept.
REQ-006 SHALL have port cin, input, 1: carry-in, sampled on accept.
REQ-007 SHALL have port in_valid, input, 1: upstream offers A/B/cin.
REQ-008 SHALL have port in_ready, output, 1: block can accept an operand set.
REQ-009 SHALL have port out, output, W: registered sum.
REQ-010 SHALL have port cout, output, 1: registered final carry-out.
REQ-011 SHALL have port out_valid, output, 1: out/cout hold a completed result.
REQ-012 SHALL have port out_ready, input, 1: downstream consumes result.

Function
REQ-013 SHALL implement an FSM with states IDLE, ADD, DONE.
REQ-014 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE (both decoded from state, no combinational path from in_valid or out_ready).
REQ-015 SHALL accept in IDLE on a rising edge with in_valid=1: latch A, B, cin; clear nibble counter to 0; go to ADD.
REQ-016 SHALL, in ADD, on each edge add nibble i of A, nibble i of B and the carry register with 4-bit carry-lookahead logic; write the 4-bit result into out[4i+3:4i]; load the nibble carry-out into the carry register; increment i.
REQ-017 SHALL leave ADD for DONE on the edge processing nibble NIBBLES-1 and load cout with that nibble's carry-out on the same edge.
REQ-018 SHALL assert out_valid exactly NIBBLES edges after the accept edge (4 edges at default).
REQ-019 SHALL satisfy {cout,out} = A + B + cin (W+1-bit result, modulo-free) for every accepted operand set.
REQ-020 SHALL, in DONE, hold out, cout, out_valid stable while out_ready=0 for any number of cycles.
REQ-021 SHALL, in DONE with out_ready=1 at an edge, return to IDLE; out and cout keep their last value; out_valid falls.
REQ-022 SHALL ignore in_valid in ADD and DONE (no latch, no queueing); a new accept occurs earliest on the edge after the return to IDLE.
REQ-023 SHALL not alter out bits of unprocessed nibbles during ADD beyond the nibble written that edge.
REQ-024 SHALL wrap the nibble counter only via the ADD->DONE transition; counter never exceeds NIBBLES-1.
REQ-025 SHALL treat cin=1 with all-ones operands correctly: A=B=all-ones, cin=1 gives out=all-ones, cout=1.

Reset
REQ-026 SHALL, on rst_n=0 (immediately, without waiting for clk): state=IDLE, counter=0, carry register=0, out=0, cout=0, out_valid=0, in_ready=1.
REQ-027 SHALL, on reset asserted during ADD or DONE, abort the operation and discard any partial result; first accept possible on the first rising edge with rst_n=1 and in_valid=1.

Verification
REQ-028 SHALL cover: A=16'h000A, B=16'h000B, cin=0 -> out_valid after 4 edges, out=16'h0015, cout=0.
REQ-029 SHALL cover: A=16'hFFFF, B=16'h0001, cin=0 -> out=16'h0000, cout=1 (carry rippled through all nibbles).
REQ-030 SHALL cover: A=16'h8888, B=16'h9999, cin=1 -> out=16'h2222, cout=1.
REQ-031 SHALL cover backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 -> out/cout/out_valid stable, in_ready=0, second operand set accepted only after out_ready=1 edge plus one edge.
REQ-032 SHALL cover reset mid-ADD: rst_n low after 2nd ADD edge -> out=0, cout=0, out_valid=0, in_ready=1 immediately; then A=16'h1234, B=16'h4321, cin=0 -> out=16'h5555, cout=0.
REQ-033 SHALL run a self-checking random loop (>=1000 operand sets, random in_valid/out_ready) comparing {cout,out} against A+B+cin.
